// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan controller with binary display and a
// serial double-dabble binary-to-BCD converter feeding a tear-free display register.
module display_scan_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned PRESCALE = 100000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [WIDTH-1:0]            number,
    input  logic                        mode,
    input  logic                        load,
    input  logic                        blank,
    output logic                        busy,
    output logic                        done,
    output logic [DIGITS-1:0]           an,
    output logic [6:0]                  seg,
    output logic [$clog2(DIGITS)-1:0]   digit_idx
);

    localparam int unsigned IDXW = $clog2(DIGITS);
    localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DW   = 4 * DIGITS;
    localparam int unsigned SW   = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state, state_d;
    logic [WIDTH-1:0] sh, sh_d;
    logic [DW-1:0]   bcd, bcd_d, bcd_adj, bcd_nx;
    logic [SW-1:0]   step, step_d;
    logic [DW-1:0]   disp, disp_d;
    logic            dmode, dmode_d;
    logic            busy_d, done_d;
    logic [PW-1:0]   pcnt;
    logic [DW-1:0]   disp_sh, disp_nib;
    logic [6:0]      seg_c;
    logic [DIGITS-1:0] an_c;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h7F;
        endcase
    endfunction

    // One double-dabble step: add-3 correction on every nibble, then shift in the next MSB.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_nx = {bcd_adj[DW-2:0], sh[WIDTH-1]};
    end

    always_comb begin
        state_d = state;
        sh_d    = sh;
        bcd_d   = bcd;
        step_d  = step;
        disp_d  = disp;
        dmode_d = dmode;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    if (mode) begin
                        state_d = CONV;
                        sh_d    = number;
                        bcd_d   = '0;
                        step_d  = '0;
                        busy_d  = 1'b1;
                    end else begin
                        disp_d  = DW'(number);
                        dmode_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            CONV: begin
                bcd_d  = bcd_nx;
                sh_d   = sh << 1;
                step_d = step + SW'(1);
                // Last step commits straight from the combinational result.
                if (step == SW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    disp_d  = bcd_nx;
                    dmode_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sh    <= '0;
            bcd   <= '0;
            step  <= '0;
            disp  <= '0;
            dmode <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            sh    <= sh_d;
            bcd   <= bcd_d;
            step  <= step_d;
            disp  <= disp_d;
            dmode <= dmode_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Glyph selection for the digit currently addressed.
    always_comb begin
        disp_sh  = disp >> digit_idx;
        disp_nib = disp >> {digit_idx, 2'b00};
        an_c     = ~(DIGITS'(1) << digit_idx);
        if (!dmode) begin
            if (32'(digit_idx) < WIDTH) begin
                seg_c = disp_sh[0] ? 7'h79 : 7'h40;
            end else begin
                seg_c = 7'h7F;
            end
        end else if ((digit_idx != '0) && (disp_nib[DW-1:4] == '0) && (disp_nib[3:0] == 4'd0)) begin
            seg_c = 7'h7F;
        end else begin
            seg_c = glyph(disp_nib[3:0]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt      <= '0;
            digit_idx <= '0;
            an        <= '1;
            seg       <= 7'h7F;
        end else begin
            if (pcnt == PW'(PRESCALE - 1)) begin
                pcnt      <= '0;
                digit_idx <= (digit_idx == IDXW'(DIGITS - 1)) ? '0 : digit_idx + IDXW'(1);
            end else begin
                pcnt <= pcnt + PW'(1);
            end
            an  <= blank ? '1 : an_c;
            seg <= seg_c;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl using a value-level display model.
module tb_display_scan_ctrl;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DIGITS   = 8;
    localparam int unsigned PRESCALE = 4;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] number;
    logic             mode;
    logic             load;
    logic             blank;
    logic             busy;
    logic             done;
    logic [DIGITS-1:0] an;
    logic [6:0]       seg;
    logic [2:0]       digit_idx;

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;
    int cyc;
    int mval;
    bit mmode;
    logic [6:0] glyph_tab [10];

    display_scan_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .reset_n(reset_n), .number(number), .mode(mode), .load(load),
        .blank(blank), .busy(busy), .done(done), .an(an), .seg(seg), .digit_idx(digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen since the last reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected glyph of digit d for the last committed value.
    function automatic logic [6:0] exp_seg(input int d);
        int p;
        if (!mmode) begin
            if (d >= int'(WIDTH)) return 7'h7F;
            return ((mval >> d) & 1) != 0 ? glyph_tab[1] : glyph_tab[0];
        end
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        if (d > 0 && mval < p) return 7'h7F;
        return glyph_tab[(mval / p) % 10];
    endfunction

    task automatic scan_cycles(input int n);
        int idx;
        int prev;
        logic [7:0] e_an;
        repeat (n) begin
            @(negedge clk);
            idx  = (cyc / PRESCALE) % DIGITS;
            prev = ((cyc - 1) / PRESCALE) % DIGITS;
            e_an = ~(8'(1) << prev);
            check("digit_idx", 32'(digit_idx), 32'(idx));
            check("busy_idle", 32'(busy), 32'(0));
            check("done_idle", 32'(done), 32'(0));
            if (blank) begin
                check("an_blank", 32'(an), 32'(8'hFF));
            end else begin
                check("an", 32'(an), 32'(e_an));
                check("seg", 32'(seg), 32'(exp_seg(prev)));
            end
        end
    endtask

    // Caller sits at a negedge. interfere: 0 none, 1 random, 2 forced load of 99.
    task automatic do_load(input int num, input bit md, input int interfere);
        number = 8'(num);
        mode   = md;
        load   = 1'b1;
        @(negedge clk);
        if (!md) begin
            check("bin_done", 32'(done), 32'(1));
            check("bin_busy", 32'(busy), 32'(0));
            load  = 1'b0;
            mval  = num;
            mmode = 1'b0;
            @(negedge clk);
            check("bin_done_end", 32'(done), 32'(0));
            check("bin_busy_end", 32'(busy), 32'(0));
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (i > 0) @(negedge clk);
                check("conv_busy", 32'(busy), 32'(1));
                check("conv_done", 32'(done), 32'(0));
                if (interfere == 1) begin
                    load   = 1'($urandom_range(0, 1));
                    number = 8'($urandom_range(0, 255));
                    mode   = 1'($urandom_range(0, 1));
                end else if (interfere == 2) begin
                    load   = 1'b1;
                    number = 8'd99;
                    mode   = 1'b1;
                end else begin
                    load = 1'b0;
                end
            end
            @(negedge clk);
            check("conv_commit_done", 32'(done), 32'(1));
            check("conv_commit_busy", 32'(busy), 32'(0));
            load  = 1'b0;
            mval  = num;
            mmode = 1'b1;
            @(negedge clk);
            check("conv_done_end", 32'(done), 32'(0));
        end
    endtask

    initial begin
        glyph_tab[0] = 7'h40; glyph_tab[1] = 7'h79; glyph_tab[2] = 7'h24;
        glyph_tab[3] = 7'h30; glyph_tab[4] = 7'h19; glyph_tab[5] = 7'h12;
        glyph_tab[6] = 7'h02; glyph_tab[7] = 7'h78; glyph_tab[8] = 7'h00;
        glyph_tab[9] = 7'h10;
        mval    = 0;
        mmode   = 1'b0;
        reset_n = 1'b1;
        number  = '0;
        mode    = 1'b0;
        load    = 1'b0;
        blank   = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_an", 32'(an), 32'(8'hFF));
        check("rst_seg", 32'(seg), 32'(7'h7F));
        check("rst_idx", 32'(digit_idx), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Scanning after release, binary zero on all digits.
        scan_cycles(70);

        // Binary display of A5.
        do_load(32'hA5, 1'b0, 0);
        scan_cycles(34);

        // Decimal 255 with random disturbance on the inputs during conversion.
        do_load(255, 1'b1, 1);
        scan_cycles(34);

        // Decimal zero, second load of 99 while busy must be ignored.
        do_load(0, 1'b1, 2);
        scan_cycles(34);

        // Randomized loads in both modes.
        repeat (6) begin
            do_load(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1);
            scan_cycles(34);
        end

        // Blanking keeps scanning alive; output resumes after release.
        do_load(137, 1'b1, 0);
        blank = 1'b1;
        scan_cycles(10);
        blank = 1'b0;
        scan_cycles(34);

        // Reset in the middle of a conversion aborts it.
        number = 8'd200;
        mode   = 1'b1;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'(1));
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_an", 32'(an), 32'(8'hFF));
        check("abort_seg", 32'(seg), 32'(7'h7F));
        check("abort_idx", 32'(digit_idx), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        mval  = 0;
        mmode = 1'b0;
        scan_cycles(40);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH  8  input value width in bits.
  DIGITS  8  number of multiplexed seven-segment digits; SHALL be >= WIDTH for binary display and >= decimal digit count of 2^WIDTH-1.
  PRESCALE  100000  clk cycles per digit slot; SHALL be >= 2.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  number  in  WIDTH  value to display.
  mode  in  1  0 = binary (one bit per digit), 1 = unsigned decimal.
  load  in  1  capture request for number and mode.
  blank  in  1  1 = all digits off.
  busy  out  1  decimal conversion in progress.
  done  out  1  one-cycle pulse when the new value is committed to the display.
  an  out  DIGITS  digit enables, active-low, bit i = digit i (digit 0 rightmost).
  seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
  digit_idx  out  $clog2(DIGITS)  digit currently driven.

Function
REQ-003 Prescaler SHALL count 0..PRESCALE-1 and wrap; digit_idx SHALL advance by 1 on the wrap edge, going from DIGITS-1 to 0.
REQ-004 an and seg SHALL be registered and SHALL reflect digit_idx one clk after digit_idx changes; exactly one an bit SHALL be low when blank=0.
REQ-005 blank=1 sampled at an edge SHALL drive an to all ones from that edge; scanning and conversion SHALL continue.
REQ-006 Control FSM states: IDLE, CONV.
REQ-007 IDLE with load=1 and mode=0: number and mode SHALL commit to the display register at that edge; done=1 for the next cycle; busy stays 0.
REQ-008 IDLE with load=1 and mode=1: number SHALL be captured, and the FSM SHALL go to CONV with busy=1 from that edge.
REQ-009 CONV SHALL perform one double-dabble step per clk (add 3 to each BCD nibble >= 5, then shift left one bit); after exactly WIDTH steps it SHALL commit the BCD result to the display register, set busy=0 and done=1 for one cycle, and return to IDLE.
REQ-010 Decimal latency: load sampled at edge k SHALL produce the commit at edge k+WIDTH; busy SHALL be high for exactly WIDTH cycles.
REQ-011 load while busy=1 SHALL be ignored, with no queuing; the in-flight conversion SHALL be unaffected by changes on number or mode.
REQ-012 The display SHALL show only the last committed value, never partial conversion state, so there is no tearing.
REQ-013 Binary mode: digit i SHALL show glyph '1' if bit i = 1 and '0' otherwise, for i < WIDTH; digits i >= WIDTH SHALL be blank (seg = 7'h7F, an still scanned).
REQ-014 Decimal mode: digit i SHALL show BCD nibble i; leading zeros above the most significant nonzero digit SHALL be blank; digit 0 SHALL always show, so value 0 shows '0'.
REQ-015 Glyphs, active-low {g..a}: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; blank=7'h7F.

Reset
REQ-016 On reset_n low, asynchronously: prescaler=0, digit_idx=0, FSM=IDLE, busy=0, done=0, an=all ones, seg=7'h7F, display register=0, committed mode=0.
REQ-017 Reset asserted mid-CONV SHALL abort the conversion; no done pulse and no commit SHALL follow.
REQ-018 After reset_n release, scanning SHALL begin on the first clk edge; the first load SHALL be accepted on any edge.

Verification (WIDTH=8, DIGITS=8, PRESCALE=4)
REQ-019 Reset release, no load -> digit_idx steps 0..7 every 4 clk and wraps; an cycles FE,FD,...,7F; seg on digit 0 = 40 and all others = 40 (binary 0).
REQ-020 load with number=8'hA5, mode=0 -> done 1 cycle later; digits 0..7 show 1,0,1,0,0,1,0,1 (79,40,79,40,40,79,40,79); busy never 1.
REQ-021 load with number=8'd255, mode=1 -> busy high 8 cycles; done at edge k+8; digits 0..2 show 5,5,2 (12,12,24); digits 3..7 show 7F.
REQ-022 load with number=0, mode=1, then a second load with 8'd99 during busy -> second load ignored; display shows '0' on digit 0 with all other digits blank.
REQ-023 reset_n pulsed low at CONV step 4 -> busy=0 and an=FF immediately; no done pulse; display register=0.
REQ-024 blank=1 for 10 cycles during scanning -> an=FF throughout; digit_idx keeps advancing; normal output resumes 1 cycle after blank=0.
